// File: rtl/req_qos_arb_pkg.sv
// Shared types and constants for the QoS request arbiter in front of the SDRAM controller.
// Holds the FSM encoding, default field widths and the fixed master slot numbers.
package req_qos_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_GAP  = 2'd3
   } arb_state_e;

   localparam int DEF_LW = 8;
   localparam int DEF_MW = 4;
   localparam int DEF_DW = 32;
   localparam int DEF_AW = 32;

   localparam int MST_CPU = 0;
   localparam int MST_VGA = 1;

endpackage

// File: rtl/req_qos_arb_rr_pick.sv
// Combinational round-robin picker: the first set request at or after the pointer wins.
// The result is a one-hot vector, or all-zero when nothing is requesting.
module rr_pick
   import req_qos_arb_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   int   idx;
   logic found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_qos_arb.sv
// Arbitrates several bursting masters onto one SDRAM request port, urgent masters first.
// The owner is held from grant through its whole burst plus one idle gap cycle.
module req_qos_arb
   import req_qos_arb_pkg::*;
#(
   parameter int MASTERS = 3,
   parameter int LW      = DEF_LW,
   parameter int MW      = DEF_MW,
   parameter int DW      = DEF_DW,
   parameter int AW      = DEF_AW
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [MASTERS-1:0]    m_req_valid,
   output logic [MASTERS-1:0]    m_req_ready,
   input  logic [MASTERS*LW-1:0] m_req_len,
   input  logic [MASTERS*MW-1:0] m_req_mask,
   input  logic [MASTERS*AW-1:0] m_req_addr,
   input  logic [MASTERS-1:0]    m_req_we,
   input  logic [MASTERS-1:0]    m_req_wrap,
   input  logic [MASTERS-1:0]    m_urgent,
   input  logic [MASTERS-1:0]    m_write_valid,
   input  logic [MASTERS*DW-1:0] m_write_data,
   output logic [MASTERS-1:0]    m_read_valid,
   output logic [MASTERS*DW-1:0] m_read_data,
   input  logic [MASTERS-1:0]    m_read_ack,
   output logic                  req_valid,
   output logic [LW-1:0]         req_len,
   output logic [MW-1:0]         req_mask,
   output logic [AW-1:0]         req_addr,
   output logic                  req_we,
   output logic                  req_wrap,
   input  logic                  req_ready,
   output logic                  write_valid,
   output logic [DW-1:0]         write_data,
   input  logic                  read_valid,
   input  logic [DW-1:0]         read_data,
   output logic                  read_ack,
   output logic [MASTERS-1:0]    grant
);

   localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

   arb_state_e         state_q, state_d;
   logic [MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [LW-1:0]      cnt_q, cnt_d;
   logic               we_q, we_d;

   logic [MASTERS-1:0] urgentGnt, normalGnt, winner;
   logic [PW-1:0]      winIdx;
   logic               selValid, selWe, selWrap, selWriteValid, selReadAck;
   logic [LW-1:0]      selLen;
   logic [MW-1:0]      selMask;
   logic [AW-1:0]      selAddr;
   logic [DW-1:0]      selWriteData;
   logic               beat;

   rr_pick #(.N(MASTERS), .PW(PW)) u_pick_urgent (
      .req_i (m_req_valid & m_urgent),
      .ptr_i (ptr_q),
      .gnt_o (urgentGnt)
   );

   rr_pick #(.N(MASTERS), .PW(PW)) u_pick_normal (
      .req_i (m_req_valid),
      .ptr_i (ptr_q),
      .gnt_o (normalGnt)
   );

   assign winner = (|(m_req_valid & m_urgent)) ? urgentGnt : normalGnt;

   always_comb begin
      winIdx = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (winner[i]) winIdx = PW'(i);
      end
   end

   // Everything the owner drives is muxed from the registered grant, never from the live winner.
   always_comb begin
      selValid      = 1'b0;
      selLen        = '0;
      selMask       = '0;
      selAddr       = '0;
      selWe         = 1'b0;
      selWrap       = 1'b0;
      selWriteValid = 1'b0;
      selWriteData  = '0;
      selReadAck    = 1'b0;
      for (int i = 0; i < MASTERS; i++) begin
         if (grant_q[i]) begin
            selValid      = m_req_valid[i];
            selLen        = m_req_len[i*LW +: LW];
            selMask       = m_req_mask[i*MW +: MW];
            selAddr       = m_req_addr[i*AW +: AW];
            selWe         = m_req_we[i];
            selWrap       = m_req_wrap[i];
            selWriteValid = m_write_valid[i];
            selWriteData  = m_write_data[i*DW +: DW];
            selReadAck    = m_read_ack[i];
         end
      end
   end

   assign beat = (state_q == ST_XFER) &&
                 (we_q ? selWriteValid : (read_valid && selReadAck));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
      end
   end

   // The counter holds beats remaining minus one, so a zero-length request is a single beat.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      case (state_q)
         ST_IDLE: begin
            if (|m_req_valid) begin
               state_d = ST_REQ;
               grant_d = winner;
               ptr_d   = (winIdx == PW'(MASTERS - 1)) ? '0 : winIdx + 1'b1;
            end
         end
         ST_REQ: begin
            if (!selValid) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end else if (req_ready) begin
               state_d = ST_XFER;
               cnt_d   = selLen;
               we_d    = selWe;
            end
         end
         ST_XFER: begin
            if (beat) begin
               if (cnt_q == '0) state_d = ST_GAP;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      grant       = grant_q;
      req_valid   = (state_q == ST_REQ) && selValid;
      req_len     = selLen;
      req_mask    = selMask;
      req_addr    = selAddr;
      req_we      = selWe;
      req_wrap    = selWrap;
      m_req_ready = ((state_q == ST_REQ) && req_ready) ? grant_q : '0;
      write_valid = (state_q == ST_XFER) && we_q && selWriteValid;
      write_data  = ((state_q == ST_XFER) && we_q) ? selWriteData : '0;
      read_ack    = (state_q == ST_XFER) && !we_q && selReadAck;
      m_read_valid = '0;
      m_read_data  = '0;
      for (int i = 0; i < MASTERS; i++) begin
         m_read_valid[i] = (state_q == ST_XFER) && !we_q && grant_q[i] && read_valid;
         if (grant_q[i]) m_read_data[i*DW +: DW] = read_data;
      end
   end

endmodule

// File: tb/tb_req_qos_arb.sv
// Directed bench for req_qos_arb: arbitration order, burst lengths, no preemption and async reset.
// Every expected value below is worked out by hand from the arbitration rules.
module tb_req_qos_arb;
   import req_qos_arb_pkg::*;

   localparam int M  = 3;
   localparam int LW = 8;
   localparam int MW = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [M-1:0]    m_req_valid, m_req_ready, m_req_we, m_req_wrap, m_urgent;
   logic [M*LW-1:0] m_req_len;
   logic [M*MW-1:0] m_req_mask;
   logic [M*AW-1:0] m_req_addr;
   logic [M-1:0]    m_write_valid, m_read_valid, m_read_ack;
   logic [M*DW-1:0] m_write_data, m_read_data;
   logic            req_valid, req_we, req_wrap, req_ready;
   logic [LW-1:0]   req_len;
   logic [MW-1:0]   req_mask;
   logic [AW-1:0]   req_addr;
   logic            write_valid, read_valid, read_ack;
   logic [DW-1:0]   write_data, read_data;
   logic [M-1:0]    grant;

   int vectors = 0;
   int miscompares = 0;
   int beats, cyc;

   req_qos_arb #(.MASTERS(M), .LW(LW), .MW(MW), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rstn(rstn),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_req_len(m_req_len), .m_req_mask(m_req_mask), .m_req_addr(m_req_addr),
      .m_req_we(m_req_we), .m_req_wrap(m_req_wrap), .m_urgent(m_urgent),
      .m_write_valid(m_write_valid), .m_write_data(m_write_data),
      .m_read_valid(m_read_valid), .m_read_data(m_read_data), .m_read_ack(m_read_ack),
      .req_valid(req_valid), .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr),
      .req_we(req_we), .req_wrap(req_wrap), .req_ready(req_ready),
      .write_valid(write_valid), .write_data(write_data),
      .read_valid(read_valid), .read_data(read_data), .read_ack(read_ack),
      .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int i, input logic [7:0] len, input logic [31:0] addr, input logic we);
      m_req_len[i*LW +: LW]  = len;
      m_req_addr[i*AW +: AW] = addr;
      m_req_we[i]            = we;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      m_req_valid = '0; m_req_len = '0; m_req_mask = '0; m_req_addr = '0;
      m_req_we = '0; m_req_wrap = '0; m_urgent = '0; m_write_valid = '0;
      m_write_data = '0; m_read_ack = '0; req_ready = 1'b0;
      read_valid = 1'b0; read_data = '0;

      // Reset state while requests are already pending
      m_req_valid = 3'b011;
      #12;
      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_req_valid", 32'(req_valid), 32'h0);
      checkOutput("rst_m_req_ready", 32'(m_req_ready), 32'h0);
      checkOutput("rst_write_valid", 32'(write_valid), 32'h0);
      checkOutput("rst_read_ack", 32'(read_ack), 32'h0);
      rstn = 1'b1;

      // CPU and VGA together, nobody urgent: CPU first, VGA after the gap
      setReq(MST_CPU, 8'd0, 32'h0000_0100, 1'b1);
      setReq(MST_VGA, 8'd0, 32'h0000_0200, 1'b0);
      m_req_mask[MST_CPU*MW +: MW] = 4'hA;
      m_req_wrap[MST_CPU] = 1'b1;
      applyStimulus();
      checkOutput("s1_grant_cpu", 32'(grant), 32'h1);
      checkOutput("s1_req_valid", 32'(req_valid), 32'h1);
      checkOutput("s1_req_addr", req_addr, 32'h0000_0100);
      checkOutput("s1_req_mask", 32'(req_mask), 32'hA);
      checkOutput("s1_req_wrap", 32'(req_wrap), 32'h1);
      checkOutput("s1_m_req_ready_low", 32'(m_req_ready), 32'h0);
      req_ready = 1'b1;
      #1;
      checkOutput("s1_m_req_ready", 32'(m_req_ready), 32'h1);
      applyStimulus();
      req_ready = 1'b0;
      m_write_valid = 3'b011;
      m_write_data[0 +: DW]  = 32'hCAFE_0001;
      m_write_data[DW +: DW] = 32'hDEAD_0002;
      #1;
      checkOutput("s1_write_valid", 32'(write_valid), 32'h1);
      checkOutput("s1_write_data", write_data, 32'hCAFE_0001);
      applyStimulus();
      m_write_valid = '0;
      m_req_valid = 3'b010;
      #1;
      checkOutput("s1_gap_grant", 32'(grant), 32'h1);
      checkOutput("s1_gap_write_valid", 32'(write_valid), 32'h0);
      applyStimulus();
      checkOutput("s1_idle_grant", 32'(grant), 32'h0);
      applyStimulus();
      checkOutput("s1_grant_vga", 32'(grant), 32'h2);
      checkOutput("s1_vga_addr", req_addr, 32'h0000_0200);
      req_ready = 1'b1;
      applyStimulus();
      req_ready = 1'b0;
      read_valid = 1'b1;
      read_data = 32'h0000_BEEF;
      m_read_ack = 3'b010;
      #1;
      checkOutput("s1_m_read_valid", 32'(m_read_valid), 32'h2);
      checkOutput("s1_m_read_data_vga", m_read_data[DW +: DW], 32'h0000_BEEF);
      checkOutput("s1_m_read_data_cpu", m_read_data[0 +: DW], 32'h0);
      checkOutput("s1_read_ack", 32'(read_ack), 32'h1);
      applyStimulus();
      read_valid = 1'b0;
      m_read_ack = '0;
      m_req_valid = '0;
      #1;
      checkOutput("s1_vga_gap_read_valid", 32'(m_read_valid), 32'h0);
      applyStimulus();

      // Pointer back to 0, VGA urgent: VGA wins, then withdraws before req_ready
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      m_req_valid = 3'b011;
      m_urgent = 3'b010;
      applyStimulus();
      checkOutput("s2_grant_vga_urgent", 32'(grant), 32'h2);
      m_req_valid = 3'b001;
      m_urgent = '0;
      #1;
      checkOutput("s2_withdraw_req_valid", 32'(req_valid), 32'h0);
      applyStimulus();
      checkOutput("s2_withdraw_idle", 32'(grant), 32'h0);
      applyStimulus();
      checkOutput("s2_then_cpu", 32'(grant), 32'h1);
      m_req_valid = '0;
      applyStimulus();

      // VGA 8-beat read with ack held low for three cycles
      setReq(MST_VGA, 8'd7, 32'h0000_3000, 1'b0);
      m_req_valid = 3'b010;
      applyStimulus();
      checkOutput("s3_grant_vga", 32'(grant), 32'h2);
      checkOutput("s3_req_len", 32'(req_len), 32'h7);
      req_ready = 1'b1;
      applyStimulus();
      req_ready = 1'b0;
      m_req_valid = '0;
      beats = 0;
      cyc = 0;
      for (int c = 0; c < 40; c++) begin
         read_valid = 1'b1;
         read_data = 32'h1000 + 32'(c);
         m_read_ack = (c >= 3 && c < 6) ? 3'b000 : 3'b010;
         #1;
         if (m_read_valid[1] !== 1'b1) break;
         if (c == 4) checkOutput("s3_read_ack_stall", 32'(read_ack), 32'h0);
         if (read_ack) beats++;
         cyc++;
         applyStimulus();
      end
      checkOutput("s3_acked_beats", 32'(beats), 32'd8);
      checkOutput("s3_xfer_cycles", 32'(cyc), 32'd11);
      checkOutput("s3_gap_grant", 32'(grant), 32'h2);
      read_valid = 1'b0;
      m_read_ack = '0;
      applyStimulus();
      checkOutput("s3_idle_grant", 32'(grant), 32'h0);

      // CPU single-beat write; grant drops two cycles after the beat
      setReq(MST_CPU, 8'd0, 32'h0000_4000, 1'b1);
      m_req_valid = 3'b001;
      applyStimulus();
      checkOutput("s4_grant_cpu", 32'(grant), 32'h1);
      req_ready = 1'b1;
      applyStimulus();
      req_ready = 1'b0;
      m_req_valid = '0;
      m_write_valid = 3'b001;
      m_write_data[0 +: DW] = 32'h5555_AAAA;
      #1;
      checkOutput("s4_write_valid", 32'(write_valid), 32'h1);
      checkOutput("s4_write_data", write_data, 32'h5555_AAAA);
      applyStimulus();
      checkOutput("s4_gap_no_beat", 32'(write_valid), 32'h0);
      checkOutput("s4_gap_grant", 32'(grant), 32'h1);
      m_write_valid = '0;
      applyStimulus();
      checkOutput("s4_grant_cleared", 32'(grant), 32'h0);

      // VGA 256-beat read; CPU turns urgent mid-burst but must wait
      setReq(MST_VGA, 8'd255, 32'h0000_8000, 1'b0);
      m_req_valid = 3'b010;
      applyStimulus();
      checkOutput("s5_grant_vga", 32'(grant), 32'h2);
      req_ready = 1'b1;
      applyStimulus();
      req_ready = 1'b0;
      m_req_valid = '0;
      beats = 0;
      for (int c = 0; c < 300; c++) begin
         read_valid = 1'b1;
         m_read_ack = 3'b010;
         if (c == 10) begin
            m_req_valid = 3'b001;
            m_urgent = 3'b001;
            setReq(MST_CPU, 8'd0, 32'h0000_9000, 1'b1);
         end
         #1;
         if (!(grant === 3'b010 && m_read_valid[1] === 1'b1)) break;
         beats++;
         applyStimulus();
      end
      checkOutput("s5_vga_beats", 32'(beats), 32'd256);
      checkOutput("s5_gap_grant", 32'(grant), 32'h2);
      read_valid = 1'b0;
      m_read_ack = '0;
      applyStimulus();
      checkOutput("s5_idle_grant", 32'(grant), 32'h0);
      applyStimulus();
      checkOutput("s5_cpu_after", 32'(grant), 32'h1);
      m_req_valid = '0;
      m_urgent = '0;
      applyStimulus();

      // Reset during beat 4 of an 8-beat CPU write
      setReq(MST_CPU, 8'd7, 32'h0000_A000, 1'b1);
      m_req_valid = 3'b001;
      applyStimulus();
      req_ready = 1'b1;
      applyStimulus();
      req_ready = 1'b0;
      m_req_valid = '0;
      m_write_valid = 3'b001;
      for (int c = 0; c < 3; c++) begin
         m_write_data[0 +: DW] = 32'h7000 + 32'(c);
         applyStimulus();
      end
      m_write_data[0 +: DW] = 32'h7003;
      #1;
      checkOutput("s6_beat4_valid", 32'(write_valid), 32'h1);
      rstn = 1'b0;
      #1;
      checkOutput("s6_rst_write_valid", 32'(write_valid), 32'h0);
      checkOutput("s6_rst_grant", 32'(grant), 32'h0);
      checkOutput("s6_rst_req_valid", 32'(req_valid), 32'h0);
      checkOutput("s6_rst_read_ack", 32'(read_ack), 32'h0);
      checkOutput("s6_rst_m_read_valid", 32'(m_read_valid), 32'h0);
      rstn = 1'b1;
      applyStimulus();
      checkOutput("s6_no_beat_after", 32'(write_valid), 32'h0);
      checkOutput("s6_idle_grant", 32'(grant), 32'h0);
      m_write_valid = '0;
      m_req_valid = 3'b011;
      applyStimulus();
      checkOutput("s6_ptr_zero", 32'(grant), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/req_qos_arb.md
REQ_QOS_ARB -- requirements
Module: req_qos_arb

Interface
REQ-001 Parameter MASTERS, 3, number of requesting masters (index 0 = CPU, 1 = VGA DMA, 2 = spare).
REQ-002 Parameter LW, 8, request length width; MW, 4, byte-mask width; DW, 32, data width; AW, 32, address width.
REQ-003 clk  input  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rstn  input  1  reset; asynchronous assert, active-low.
REQ-005 m_req_valid / m_req_ready  input / output  MASTERS  per-master request handshake.
REQ-006 m_req_len, m_req_mask, m_req_addr, m_req_we, m_req_wrap  input  MASTERS*{LW,MW,AW,1,1}  packed per-master request fields, master i at slice i.
REQ-007 m_urgent  input  MASTERS  per-master QoS flag (e.g. VGA line FIFO below watermark).
REQ-008 m_write_valid, m_write_data  input  MASTERS*{1,DW}  per-master write beats.
REQ-009 m_read_valid, m_read_data / m_read_ack  output / input  MASTERS*{1,DW} / MASTERS  per-master read beats.
REQ-010 req_valid, req_len, req_mask, req_addr, req_we, req_wrap / req_ready  output / input  downstream (SDRAM controller) request.
REQ-011 write_valid, write_data  output  1, DW  downstream write beats.
REQ-012 read_valid, read_data / read_ack  input / output  1, DW / 1  downstream read beats.
REQ-013 grant  output  MASTERS  one-hot current owner, all-zero when idle.

Function
REQ-014 States: IDLE, REQ, XFER, GAP; reset state IDLE.
REQ-015 IDLE: if any m_req_valid, register winner into grant and go to REQ next cycle; otherwise stay.
REQ-016 Winner: among masters with m_req_valid & m_urgent, round-robin; if none urgent, round-robin among all m_req_valid.
REQ-017 Round-robin pointer SHALL advance to winner+1 (mod MASTERS) at each grant; reset value 0.
REQ-018 REQ: req_valid=1 with granted master's fields; m_req_ready[g]=req_ready; on req_valid & req_ready go to XFER and load beat counter with req_len.
REQ-019 Burst length SHALL be req_len+1 beats (req_len 0 = 1 beat, 255 = 256 beats).
REQ-020 XFER write (req_we=1): write_valid/write_data SHALL mirror m_write_valid[g]/m_write_data[g]; each write_valid decrements counter.
REQ-021 XFER read: m_read_valid[g]/m_read_data[g] mirror read_valid/read_data; read_ack mirrors m_read_ack[g]; beat counted on read_valid & read_ack.
REQ-022 Beat with counter==0 ends transfer: go to GAP; GAP lasts exactly one cycle then IDLE.
REQ-023 Non-granted masters SHALL see m_req_ready=0, m_read_valid=0; their write beats SHALL be ignored.
REQ-024 No preemption: m_urgent changes during REQ/XFER SHALL not affect current owner.
REQ-025 Request field forwarding SHALL be combinational from registered grant; arbitration latency from m_req_valid to req_valid is 1 cycle.
REQ-026 m_req_valid withdrawn in REQ before req_ready: return to IDLE without advancing pointer further.

Reset
REQ-027 rstn low: state IDLE, grant 0, pointer 0, counter 0, req_valid 0, write_valid 0, read_ack 0, all m_req_ready/m_read_valid 0, immediately and asynchronously.
REQ-028 Reset mid-XFER SHALL abandon the burst; no beat SHALL be forwarded after rstn asserts.

Structure
REQ-029 Shared package: state encoding, default LW/MW/DW/AW constants, master index constants (CPU, VGA).
REQ-030 One sub-module, rr_pick: combinational MASTERS-wide round-robin picker (request vector, pointer -> one-hot winner), instantiated twice (urgent, normal).

Verification
REQ-031 CPU and VGA request together, no urgent, pointer 0 -> CPU granted, then VGA after GAP.
REQ-032 CPU and VGA request, m_urgent[1]=1, pointer 0 -> VGA granted first.
REQ-033 VGA read req_len=7, read_ack held low 3 cycles mid-burst -> exactly 8 acked beats reach VGA, then GAP, IDLE.
REQ-034 CPU write req_len=0 -> single write_valid beat forwarded, grant clears 2 cycles later.
REQ-035 m_urgent[0] rises during VGA 256-beat burst -> VGA keeps grant until beat 256.
REQ-036 rstn pulsed low at beat 4 of 8 -> all outputs 0 same cycle, state IDLE, pointer 0.
